// File: rtl/lcd_feeder_pkg.sv
// rtl/lcd_feeder_pkg.sv - shared state encoding, defaults and colour-bar constants for the LCD pixel feeder
package lcd_feeder_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, PRIME, RUN} feeder_state_t;

  localparam int          DEF_DATA_W      = 16;
  localparam logic [15:0] DEF_FILL_COLOR  = 16'h0000;
  localparam int          DEF_PRIME_LEVEL = 256;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_color_bar.sv
// rtl/lcd_color_bar.sv - eight-bar test pattern generator driven by the driver's pixel request
module lcd_color_bar
  import lcd_feeder_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BAR_WIDTH = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_request,
  output logic [DATA_W-1:0] bar_data
);

  localparam int PX_W = $clog2(BAR_WIDTH + 1);

  // Pixel position kept as (offset within bar, bar index) so no divider is needed.
  logic [PX_W-1:0] px_cnt;
  logic [2:0]      bar_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt   <= '0;
      bar_idx  <= '0;
      bar_data <= '0;
    end else if (lcd_request) begin
      bar_data <= DATA_W'(bar_color(bar_idx));
      if (px_cnt == PX_W'(BAR_WIDTH - 1)) begin
        px_cnt  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        px_cnt <= px_cnt + 1'b1;
      end
    end else begin
      px_cnt  <= '0;
      bar_idx <= '0;
    end
  end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// rtl/lcd_pixel_feeder.sv - feeds SDRAM read-FIFO pixels to the LCD timing driver, resyncing every frame
// Optional colour-bar test pattern selected at build time with LCD_FEEDER_PATTERN_EN.
module lcd_pixel_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                LEVEL_W      = 10,
  parameter int                PRIME_LEVEL  = DEF_PRIME_LEVEL,
  parameter int                FLUSH_CYCLES = 16,
  parameter logic [DATA_W-1:0] FILL_COLOR   = DATA_W'(DEF_FILL_COLOR)
`ifdef LCD_FEEDER_PATTERN_EN
  ,
  parameter int                BAR_WIDTH    = 80
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lcd_request,
  input  logic               lcd_framesync,
`ifdef LCD_FEEDER_PATTERN_EN
  input  logic               pattern_sel,
`endif
  output logic [DATA_W-1:0]  lcd_data,
  output logic               rdf_rd_en,
  input  logic [DATA_W-1:0]  rdf_data,
  input  logic               rdf_empty,
  input  logic [LEVEL_W-1:0] rdf_level,
  output logic               frame_restart,
  output logic               feeder_ready,
  output logic               underflow,
  output logic [15:0]        underflow_cnt
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  feeder_state_t   state, state_nxt;
  logic            vs_q;
  logic            frame_edge;
  logic [FC_W-1:0] flush_cnt;
  logic            rd_valid_q;
  logic            uf_hit;
  logic            pattern_on;
  logic [DATA_W-1:0] fifo_pixel;

`ifdef LCD_FEEDER_PATTERN_EN
  logic [DATA_W-1:0] bar_data;

  lcd_color_bar #(
    .DATA_W    (DATA_W),
    .BAR_WIDTH (BAR_WIDTH)
  ) u_color_bar (
    .clk         (clk),
    .rst_n       (rst_n),
    .lcd_request (lcd_request),
    .bar_data    (bar_data)
  );

  assign pattern_on = pattern_sel;
  assign lcd_data   = pattern_sel ? bar_data : fifo_pixel;
`else
  assign pattern_on = 1'b0;
  assign lcd_data   = fifo_pixel;
`endif

  assign frame_edge    = vs_q & ~lcd_framesync;
  assign frame_restart = (state == FLUSH);
  assign feeder_ready  = (state == RUN);
  assign fifo_pixel    = rd_valid_q ? rdf_data : FILL_COLOR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdf_rd_en = 1'b0;
    uf_hit    = 1'b0;
    case (state)
      IDLE:  state_nxt = IDLE;
      FLUSH: if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) state_nxt = PRIME;
      PRIME: if (rdf_level >= LEVEL_W'(PRIME_LEVEL) && !rdf_empty) state_nxt = RUN;
      RUN: begin
        rdf_rd_en = lcd_request & ~rdf_empty & ~pattern_on;
        uf_hit    = lcd_request &  rdf_empty & ~pattern_on;
      end
      default: state_nxt = IDLE;
    endcase
    // A new frame overrides everything, including a read requested in the same cycle.
    if (frame_edge) begin
      state_nxt = FLUSH;
      rdf_rd_en = 1'b0;
      uf_hit    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q          <= 1'b1;
      flush_cnt     <= '0;
      rd_valid_q    <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      vs_q       <= lcd_framesync;
      rd_valid_q <= rdf_rd_en;
      if (frame_edge || state != FLUSH) flush_cnt <= '0;
      else                              flush_cnt <= flush_cnt + 1'b1;
      if (frame_edge)  underflow <= 1'b0;
      else if (uf_hit) underflow <= 1'b1;
      if (uf_hit && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// tb/tb_lcd_pixel_feeder.sv - directed, table-driven bench for lcd_pixel_feeder
module tb_lcd_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lcd_request;
  logic        lcd_framesync;
  logic [15:0] lcd_data;
  logic        rdf_rd_en;
  logic [15:0] rdf_data = 16'h0000;
  logic        rdf_empty;
  logic [9:0]  rdf_level;
  logic        frame_restart;
  logic        feeder_ready;
  logic        underflow;
  logic [15:0] underflow_cnt;
`ifdef LCD_FEEDER_PATTERN_EN
  logic        pattern_sel;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] fifo_word = 16'd1;

  always #5 clk = ~clk;

  lcd_pixel_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lcd_request   (lcd_request),
    .lcd_framesync (lcd_framesync),
`ifdef LCD_FEEDER_PATTERN_EN
    .pattern_sel   (pattern_sel),
`endif
    .lcd_data      (lcd_data),
    .rdf_rd_en     (rdf_rd_en),
    .rdf_data      (rdf_data),
    .rdf_empty     (rdf_empty),
    .rdf_level     (rdf_level),
    .frame_restart (frame_restart),
    .feeder_ready  (feeder_ready),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  // FIFO with one-cycle read latency, holding the words 1, 2, 3, ...
  always @(posedge clk) begin
    if (rdf_rd_en) begin
      rdf_data  <= fifo_word;
      fifo_word <= fifo_word + 16'd1;
    end
  end

  typedef struct {
    logic        req;
    logic        empty;
    logic        exp_rd;
    logic [15:0] exp_data;
    logic        exp_uf;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!feeder_ready && n < budget) begin
      to_drive();
      @(negedge clk);
      n++;
    end
    chk("ready_within_budget", {31'd0, feeder_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_seen;
    int bad_data;
`ifdef LCD_FEEDER_PATTERN_EN
    logic [15:0] bars [8];
`endif
    vt[0] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 16'd801,  1'b0, 16'd0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd2};
    vt[4] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd3};
    vt[5] = '{1'b0, 1'b0, 1'b0, 16'd802,  1'b1, 16'd3};
    vt[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd3};
    vt[7] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd3};
    vt[8] = '{1'b0, 1'b0, 1'b0, 16'd803,  1'b1, 16'd3};

    rst_n         = 1'b0;
    lcd_request   = 1'b1;
    lcd_framesync = 1'b1;
    rdf_empty     = 1'b0;
    rdf_level     = 10'd300;
`ifdef LCD_FEEDER_PATTERN_EN
    pattern_sel   = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_lcd_data", {16'd0, lcd_data}, 32'h0);
    chk("rst_rd_en", {31'd0, rdf_rd_en}, 32'd0);
    chk("rst_frame_restart", {31'd0, frame_restart}, 32'd0);
    chk("rst_ready", {31'd0, feeder_ready}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_underflow_cnt", {16'd0, underflow_cnt}, 32'd0);

    // Idle after reset: requests toggling, FIFO full, but no frame edge yet.
    rd_seen  = 0;
    bad_data = 0;
    to_drive();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      to_drive();
      lcd_request = i[0];
      @(negedge clk);
      if (rdf_rd_en) rd_seen++;
      if (lcd_data !== 16'h0000) bad_data++;
    end
    chk("idle_no_reads", rd_seen, 0);
    chk("idle_fill_data", bad_data, 0);
    chk("idle_ready", {31'd0, feeder_ready}, 32'd0);

    // Frame edge: restart pulse for exactly 16 cycles starting the cycle after.
    to_drive();
    lcd_request   = 1'b0;
    lcd_framesync = 1'b0;
    rdf_level     = 10'd255;
    @(negedge clk);
    chk("restart_edge_cycle", {31'd0, frame_restart}, 32'd0);
    for (int k = 1; k <= 18; k++) begin
      to_drive();
      lcd_framesync = 1'b1;
      @(negedge clk);
      chk($sformatf("restart_t%0d", k), {31'd0, frame_restart}, {31'd0, (k <= 16)});
    end
    for (int i = 0; i < 10; i++) begin
      to_drive();
      @(negedge clk);
    end
    chk("prime_level_255", {31'd0, feeder_ready}, 32'd0);
    to_drive();
    rdf_level = 10'd256;
    @(negedge clk);
    to_drive();
    @(negedge clk);
    chk("prime_level_256", {31'd0, feeder_ready}, 32'd1);

    // 800-pixel request burst streamed straight from the FIFO.
    rd_seen = 0;
    for (int i = 0; i <= 800; i++) begin
      to_drive();
      lcd_request = (i < 800);
      @(negedge clk);
      if (rdf_rd_en) rd_seen++;
      if (i > 0) chk($sformatf("stream_px%0d", i), {16'd0, lcd_data}, i);
    end
    chk("stream_reads", rd_seen, 800);

    // Underflow vectors.
    for (int r = 0; r < 9; r++) begin
      to_drive();
      lcd_request = vt[r].req;
      rdf_empty   = vt[r].empty;
      @(negedge clk);
      chk($sformatf("vec%0d_rd_en", r), {31'd0, rdf_rd_en}, {31'd0, vt[r].exp_rd});
      chk($sformatf("vec%0d_data", r), {16'd0, lcd_data}, {16'd0, vt[r].exp_data});
      chk($sformatf("vec%0d_uf", r), {31'd0, underflow}, {31'd0, vt[r].exp_uf});
      chk($sformatf("vec%0d_cnt", r), {16'd0, underflow_cnt}, {16'd0, vt[r].exp_cnt});
    end

    // Frame edge in the middle of a request burst.
    to_drive();
    lcd_request = 1'b1;
    rdf_empty   = 1'b0;
    @(negedge clk);
    chk("burst_rd_en", {31'd0, rdf_rd_en}, 32'd1);
    to_drive();
    lcd_framesync = 1'b0;
    @(negedge clk);
    chk("edge_rd_en_drop", {31'd0, rdf_rd_en}, 32'd0);
    chk("edge_data", {16'd0, lcd_data}, 32'd804);
    chk("edge_uf_still_set", {31'd0, underflow}, 32'd1);
    to_drive();
    lcd_framesync = 1'b1;
    rdf_empty     = 1'b1;
    @(negedge clk);
    chk("edge_restart", {31'd0, frame_restart}, 32'd1);
    chk("edge_uf_cleared", {31'd0, underflow}, 32'd0);
    chk("edge_flush_rd_en", {31'd0, rdf_rd_en}, 32'd0);
    chk("edge_flush_data", {16'd0, lcd_data}, 32'h0);
    to_drive();
    lcd_request = 1'b0;
    rdf_empty   = 1'b0;
    @(negedge clk);
    chk("edge_cnt_kept", {16'd0, underflow_cnt}, 32'd3);
    chk("edge_not_ready", {31'd0, feeder_ready}, 32'd0);
    wait_ready(40);

    // Saturation of the underflow counter.
    to_drive();
    lcd_request = 1'b1;
    rdf_empty   = 1'b1;
    for (int i = 1; i < 65531; i++) to_drive();
    to_drive();
    lcd_request = 1'b0;
    @(negedge clk);
    chk("cnt_fffe", {16'd0, underflow_cnt}, 32'hFFFE);
    chk("uf_set_again", {31'd0, underflow}, 32'd1);
    to_drive();
    lcd_request = 1'b1;
    to_drive();
    to_drive();
    to_drive();
    lcd_request = 1'b0;
    @(negedge clk);
    chk("cnt_saturated", {16'd0, underflow_cnt}, 32'hFFFF);

`ifdef LCD_FEEDER_PATTERN_EN
    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
    rd_seen = 0;
    to_drive();
    pattern_sel = 1'b1;
    rdf_empty   = 1'b0;
    for (int i = 0; i <= 640; i++) begin
      to_drive();
      lcd_request = (i < 640);
      @(negedge clk);
      if (rdf_rd_en) rd_seen++;
      if (i > 0) chk($sformatf("bar_px%0d", i - 1), {16'd0, lcd_data}, {16'd0, bars[(i - 1) / 80]});
    end
    chk("bar_no_reads", rd_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
